// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring divider and HI/LO register owner
// DIV/DIVU take 34 cycles from accept to visible result; divide-by-zero takes 2.
module div_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        mf_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic        sign_q, sign_r, div_zero;
  logic [31:0] dq, dv, raw;
  logic [32:0] rem;
  logic [4:0]  count;

  logic [31:0] dividend_mag, divisor_mag;
  logic [32:0] rem_shift, rem_sub;
  logic        fits;
  logic [31:0] quot_fix, rem_fix;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | mf_req);

  always_comb begin
    dividend_mag = (is_signed & dividend[31]) ? (~dividend + 32'd1) : dividend;
    divisor_mag  = (is_signed & divisor[31])  ? (~divisor + 32'd1)  : divisor;
    rem_shift    = (rem << 1) | {32'd0, dq[31]};
    rem_sub      = rem_shift - {1'b0, dv};
    fits         = (rem_shift >= {1'b0, dv});
    quot_fix     = sign_q ? (~dq + 32'd1) : dq;
    rem_fix      = sign_r ? (~rem[31:0] + 32'd1) : rem[31:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == 32'd0) ? FIX : CALC;
      CALC: if (count == 5'd31) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      dq       <= '0;
      dv       <= '0;
      raw      <= '0;
      rem      <= '0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sign_q   <= is_signed & (dividend[31] ^ divisor[31]);
          sign_r   <= is_signed & dividend[31];
          dq       <= dividend_mag;
          dv       <= divisor_mag;
          raw      <= dividend;
          div_zero <= (divisor == 32'd0);
          rem      <= '0;
          count    <= '0;
        end
        CALC: begin
          // One quotient bit per cycle, shifted in from the LSB as dividend bits leave the MSB.
          rem   <= fits ? rem_sub : rem_shift;
          dq    <= {dq[30:0], fits};
          count <= count + 5'd1;
        end
        FIX: begin
          lo   <= div_zero ? 32'hFFFF_FFFF : quot_fix;
          hi   <= div_zero ? raw : rem_fix;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the `ALU_div` operation and owner of the HI/LO register pair. Decode issues a DIV or DIVU here instead of the single-cycle ALU. The block runs a 32-iteration restoring division and writes the quotient to LO and the remainder to HI. It also asserts `stall` to freeze the front of the pipeline whenever a new divide or an MFHI/MFLO would see an unfinished result.

## Interface
No parameters; datapath width fixed at 32.
- `clock` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: decode holds a DIV/DIVU this cycle (opcode `SPECIAL`, funct `DIV`/`DIVU`).
- `is_signed` in 1: 1 = DIV, 0 = DIVU; sampled with `start`.
- `dividend` in 32: rs value; sampled with `start`.
- `divisor` in 32: rt value; sampled with `start`.
- `mf_req` in 1: decode holds an MFHI or MFLO this cycle.
- `hi` out 32: HI register (remainder).
- `lo` out 32: LO register (quotient).
- `busy` out 1: state != IDLE.
- `stall` out 1: `busy & (start | mf_req)`, combinational.
- `done` out 1: one-cycle pulse, coincident with first cycle new HI/LO are visible.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: `start` accepted when in IDLE. On accept, latch the following:
  - `sign_q = is_signed & (dividend[31] ^ divisor[31])`
  - `sign_r = is_signed & dividend[31]`
  - magnitudes: two's-complement abs when `is_signed`, raw otherwise
  - raw dividend (for divide-by-zero)
  - clear 33-bit partial remainder and 5-bit counter.
- Next state on accept: FIX if divisor == 0, else CALC.
- CALC, one quotient bit per cycle, MSB first:
  - `rem = {rem[31:0], dq[31]}`
  - `dq = dq << 1`
  - if `rem >= {1'b0, dv}`: `rem -= dv` and `dq[0] = 1`.
  - Counter increments. After count 31, go to FIX.
- FIX:
  - Normal: `lo = sign_q ? -quot : quot`, `hi = sign_r ? -rem[31:0] : rem[31:0]`.
  - Divide-by-zero: `lo = 32'hFFFF_FFFF`, `hi` = raw dividend.
  - Set `done` register. Go to IDLE.
- Overflow: DIV of 0x8000_0000 by 0xFFFF_FFFF is not special-cased. The result falls out as `lo = 0x8000_0000`, `hi = 0`.
- `start` while busy: ignored and stalled. Decode holds the instruction, and it is accepted on the first IDLE cycle.
- `mf_req` while busy: stalled. In IDLE there is no stall, and decode reads `hi`/`lo` directly.
- `hi`/`lo` change only at the FIX→IDLE edge or on reset.
- Reset, including mid-CALC: state IDLE, `hi = 0`, `lo = 0`, `done = 0`, `busy = 0`, counter 0. The in-flight divide is discarded.

## Timing
- Edge 0 samples `start` in IDLE.
- CALC occupies cycles 1–32. FIX is cycle 33.
- New `hi`/`lo` are visible and `done = 1` in cycle 34: latency 34 cycles from accept.
- Divide-by-zero: FIX in cycle 1, result and `done` in cycle 2.
- `busy` is high in cycles 1–33 (cycle 1 only for divide-by-zero).
- `stall` is combinational from `busy`, `start` and `mf_req`; there is no registered delay.
- Back-to-back: a held `start` is accepted at the edge ending cycle 34. `done` for the first op and the accept of the second share that cycle.
- `mf_req` stalled during busy is released in cycle 34 and reads the new value.
- `done` is never high for two consecutive cycles.

## Test plan
- DIV 100 / 7 → cycle 34: `lo = 14`, `hi = 2`, `done = 1`; `busy` high exactly cycles 1–33.
- DIV −7 / 2 (0xFFFF_FFF9, 2) → `lo = 0xFFFF_FFFD`, `hi = 0xFFFF_FFFF`. DIVU with the same operands → `lo = 0x7FFF_FFFC`, `hi = 1`.
- Divide-by-zero, DIV 0x1234 / 0 → cycle 2: `lo = 0xFFFF_FFFF`, `hi = 0x1234`, `done = 1`, `busy` high only in cycle 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → `lo = 0x8000_0000`, `hi = 0`.
- Hazard check:
  - Stimulus: start 50 / 3, then assert `mf_req` in cycle 5, and hold a second `start` (9 / 4) from cycle 10.
  - Required: `stall = 1` through cycle 33; `mf_req` sees `lo = 16`, `hi = 2` in cycle 34; second divide accepted at edge 34 and completes with `lo = 2`, `hi = 1` at cycle 68.
- Assert `reset` asynchronously (mid-cycle) in cycle 12 of a divide → `hi = lo = 0`, `busy = done = stall = 0` immediately. A fresh divide 8 / 2 afterwards gives `lo = 4`, `hi = 0`.
